// File: rtl/adc_frame_packer.sv
// Packs each ADC conversion into a UART byte frame (header, high, low[, XOR checksum]).
// Optional checksum byte enabled by defining ADC_PKT_CHECKSUM_EN.
module adc_frame_packer #(
  parameter int unsigned WIDTH  = 10,
  parameter logic [7:0]  HEADER = 8'hA5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             eot_i,
  output logic             stt_o,
  output logic [7:0]       tx_data_o,
  output logic             busy_o,
  output logic             pend_o,
  output logic             done_o,
  output logic             drop_o,
  output logic [7:0]       drop_cnt_o
);

  localparam int unsigned EXT_W = 16;
  localparam int unsigned IDX_W = 2;
`ifdef ADC_PKT_CHECKSUM_EN
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(3);
`else
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(2);
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [7:0]         hi_q, hi_d;
  logic [7:0]         lo_q, lo_d;
  logic [EXT_W-1:0]   buf_q, buf_d;
  logic               pend_q, pend_d;
  logic               stt_q, stt_d;
  logic [7:0]         tx_q, tx_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               drop_q, drop_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [EXT_W-1:0]   data_ext;

  assign data_ext = EXT_W'(data_i);

  // Frame byte selection from the latched frame registers.
  function automatic logic [7:0] byte_at(input logic [IDX_W-1:0] idx,
                                         input logic [7:0] hi,
                                         input logic [7:0] lo);
    case (idx)
      IDX_W'(0): byte_at = HEADER;
      IDX_W'(1): byte_at = hi;
      IDX_W'(2): byte_at = lo;
`ifdef ADC_PKT_CHECKSUM_EN
      default:   byte_at = HEADER ^ hi ^ lo;
`else
      default:   byte_at = 8'h00;
`endif
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    buf_d   = buf_q;
    pend_d  = pend_q;
    stt_d   = 1'b0;
    tx_d    = tx_q;
    done_d  = 1'b0;
    drop_d  = 1'b0;
    cnt_d   = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (pend_q || valid_i) begin
          if (pend_q) begin
            hi_d   = buf_q[15:8];
            lo_d   = buf_q[7:0];
            pend_d = 1'b0;
          end else begin
            hi_d = data_ext[15:8];
            lo_d = data_ext[7:0];
          end
          idx_d   = '0;
          stt_d   = 1'b1;
          tx_d    = HEADER;
          state_d = ST_SEND;
        end
      end
      ST_SEND: state_d = ST_WAIT;
      ST_WAIT: begin
        if (eot_i) begin
          if (idx_q == LAST_IDX) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            idx_d   = IDX_W'(idx_q + IDX_W'(1));
            stt_d   = 1'b1;
            tx_d    = byte_at(IDX_W'(idx_q + IDX_W'(1)), hi_q, lo_q);
            state_d = ST_SEND;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Holding buffer: in IDLE a full buffer is being drained, so it is free again.
    if (valid_i) begin
      if (state_q == ST_IDLE) begin
        if (pend_q) begin
          buf_d  = data_ext;
          pend_d = 1'b1;
        end
      end else if (!pend_q) begin
        buf_d  = data_ext;
        pend_d = 1'b1;
      end else begin
        drop_d = 1'b1;
        if (cnt_q != 8'hFF) cnt_d = 8'(cnt_q + 8'd1);
      end
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      buf_q   <= '0;
      pend_q  <= 1'b0;
      stt_q   <= 1'b0;
      tx_q    <= 8'h00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      drop_q  <= 1'b0;
      cnt_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      buf_q   <= buf_d;
      pend_q  <= pend_d;
      stt_q   <= stt_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      drop_q  <= drop_d;
      cnt_q   <= cnt_d;
    end
  end

  assign stt_o      = stt_q;
  assign tx_data_o  = tx_q;
  assign busy_o     = busy_q;
  assign pend_o     = pend_q;
  assign done_o     = done_q;
  assign drop_o     = drop_q;
  assign drop_cnt_o = cnt_q;

endmodule

// File: tb/tb_adc_frame_packer.sv
// Directed self-checking bench for adc_frame_packer (3- or 4-byte frame per ADC_PKT_CHECKSUM_EN).
module tb_adc_frame_packer;

  logic       clk_i = 1'b0;
  logic       rst_i, valid_i, eot_i;
  logic [9:0] data_i;
  logic       stt_o, busy_o, pend_o, done_o, drop_o;
  logic [7:0] tx_data_o, drop_cnt_o;

  int checks = 0;
  int errors = 0;
  int stt_seen = 0;
  int drop_seen = 0;
  int snap;

  always #5 clk_i = ~clk_i;

  adc_frame_packer dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .data_i(data_i), .eot_i(eot_i),
    .stt_o(stt_o), .tx_data_o(tx_data_o), .busy_o(busy_o), .pend_o(pend_o),
    .done_o(done_o), .drop_o(drop_o), .drop_cnt_o(drop_cnt_o)
  );

  always @(negedge clk_i) begin
    if (stt_o) stt_seen++;
    if (drop_o) drop_seen++;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic pulse_valid(input logic [9:0] d);
    valid_i = 1'b1;
    data_i  = d;
    tick();
    valid_i = 1'b0;
  endtask

  // Entered in the SEND cycle of one byte; leaves in the cycle after its eot_i.
  // inj=1 drives valid_i during WAIT, inj=2 drives it together with eot_i.
  task automatic do_byte(input string tag, input logic [7:0] exp, input bit last,
                         input int inj, input logic [9:0] inj_d);
    check({tag, "_stt"}, 16'(stt_o), 16'd1);
    check({tag, "_data"}, 16'(tx_data_o), 16'(exp));
    tick();
    check({tag, "_stt_low"}, 16'(stt_o), 16'd0);
    if (inj == 1) begin
      valid_i = 1'b1;
      data_i  = inj_d;
    end
    tick();
    valid_i = 1'b0;
    check({tag, "_hold"}, 16'(tx_data_o), 16'(exp));
    eot_i = 1'b1;
    if (inj == 2) begin
      valid_i = 1'b1;
      data_i  = inj_d;
    end
    tick();
    eot_i   = 1'b0;
    valid_i = 1'b0;
    if (last) begin
      check({tag, "_done"}, 16'(done_o), 16'd1);
      check({tag, "_no_stt"}, 16'(stt_o), 16'd0);
    end
  endtask

  task automatic send_frame(input string tag, input logic [7:0] b1, input logic [7:0] b2,
                            input logic [7:0] chk,
                            input int inj0, input logic [9:0] d0,
                            input int inj1, input logic [9:0] d1,
                            input int injl, input logic [9:0] dl);
    do_byte({tag, "_b0"}, 8'hA5, 1'b0, inj0, d0);
    do_byte({tag, "_b1"}, b1, 1'b0, inj1, d1);
`ifdef ADC_PKT_CHECKSUM_EN
    do_byte({tag, "_b2"}, b2, 1'b0, 0, 10'h000);
    do_byte({tag, "_b3"}, chk, 1'b1, injl, dl);
`else
    if (chk == 8'h00) begin end
    do_byte({tag, "_b2"}, b2, 1'b1, injl, dl);
`endif
  endtask

  initial begin
    rst_i   = 1'b0;
    valid_i = 1'b0;
    eot_i   = 1'b0;
    data_i  = '0;
    tick();
    tick();
    check("rst_stt", 16'(stt_o), 16'd0);
    check("rst_done", 16'(done_o), 16'd0);
    check("rst_drop", 16'(drop_o), 16'd0);
    check("rst_pend", 16'(pend_o), 16'd0);
    check("rst_busy", 16'(busy_o), 16'd0);
    check("rst_tx", 16'(tx_data_o), 16'h00);
    check("rst_cnt", 16'(drop_cnt_o), 16'd0);
    rst_i = 1'b1;
    tick();

    // Single sample
    pulse_valid(10'h2B7);
    check("t1_busy", 16'(busy_o), 16'd1);
    send_frame("t1", 8'h02, 8'hB7, 8'h10, 0, 10'h0, 0, 10'h0, 0, 10'h0);
    check("t1_busy_end", 16'(busy_o), 16'd0);
    tick();
    check("t1_idle_stt", 16'(stt_o), 16'd0);
    check("t1_idle_tx", 16'(tx_data_o), 16'(8'hB7 ^ 8'h00) ^
`ifdef ADC_PKT_CHECKSUM_EN
          16'h00A7
`else
          16'h0000
`endif
          );

    // Back-to-back: second sample arrives mid-frame
    pulse_valid(10'h3FF);
    send_frame("t2a", 8'h03, 8'hFF, 8'h59, 1, 10'h001, 0, 10'h0, 0, 10'h0);
    check("t2_pend", 16'(pend_o), 16'd1);
    tick();
    check("t2_restart_2cyc", 16'(stt_o), 16'd1);
    check("t2_pend_clear", 16'(pend_o), 16'd0);
    send_frame("t2b", 8'h00, 8'h01, 8'hA4, 0, 10'h0, 0, 10'h0, 0, 10'h0);
    check("t2_no_drop", 16'(drop_seen), 16'd0);
    tick();

    // Overrun: third sample dropped, buffer keeps the older one
    pulse_valid(10'h100);
    send_frame("t3a", 8'h01, 8'h00, 8'hA4, 1, 10'h200, 1, 10'h300, 0, 10'h0);
    check("t3_drop_pulses", 16'(drop_seen), 16'd1);
    check("t3_drop_cnt", 16'(drop_cnt_o), 16'd1);
    check("t3_pend", 16'(pend_o), 16'd1);
    tick();
    send_frame("t3b", 8'h02, 8'h00, 8'hA7, 0, 10'h0, 0, 10'h0, 0, 10'h0);
    tick();

    // Stray eot_i in IDLE
    snap  = stt_seen;
    eot_i = 1'b1;
    tick();
    eot_i = 1'b0;
    tick();
    tick();
    check("t4_stray_eot", 16'(stt_seen - snap), 16'd0);
    check("t4_busy", 16'(busy_o), 16'd0);

    // valid_i coincident with final eot_i
    pulse_valid(10'h155);
    send_frame("t5a", 8'h01, 8'h55, 8'hF1, 0, 10'h0, 0, 10'h0, 2, 10'h0AA);
    check("t5_pend", 16'(pend_o), 16'd1);
    tick();
    check("t5_restart", 16'(stt_o), 16'd1);
    send_frame("t5b", 8'h00, 8'hAA, 8'h0F, 0, 10'h0, 0, 10'h0, 0, 10'h0);
    check("t5_no_drop", 16'(drop_seen), 16'd1);
    tick();

    // Saturation while parked in WAIT of byte 1, then reset mid-frame
    pulse_valid(10'h050);
    do_byte("t6_b0", 8'hA5, 1'b0, 0, 10'h0);
    check("t6_b1_data", 16'(tx_data_o), 16'h00);
    tick();
    pulse_valid(10'h123);
    check("t6_pend", 16'(pend_o), 16'd1);
    for (int i = 0; i < 253; i++) begin
      pulse_valid(10'h3C3);
      tick();
    end
    check("t6_cnt_254", 16'(drop_cnt_o), 16'd254);
    for (int i = 0; i < 47; i++) begin
      pulse_valid(10'h3C3);
      tick();
    end
    check("t6_cnt_sat", 16'(drop_cnt_o), 16'd255);
    check("t6_drop_total", 16'(drop_seen), 16'd301);
    check("t6_busy", 16'(busy_o), 16'd1);

    rst_i = 1'b0;
    tick();
    rst_i = 1'b1;
    check("t7_rst_stt", 16'(stt_o), 16'd0);
    check("t7_rst_done", 16'(done_o), 16'd0);
    check("t7_rst_drop", 16'(drop_o), 16'd0);
    check("t7_rst_pend", 16'(pend_o), 16'd0);
    check("t7_rst_busy", 16'(busy_o), 16'd0);
    check("t7_rst_tx", 16'(tx_data_o), 16'h00);
    check("t7_rst_cnt", 16'(drop_cnt_o), 16'd0);
    snap  = stt_seen;
    eot_i = 1'b1;
    tick();
    eot_i = 1'b0;
    tick();
    check("t7_eot_ignored", 16'(stt_seen - snap), 16'd0);
    check("t7_pend_after", 16'(pend_o), 16'd0);

    pulse_valid(10'h2B7);
    send_frame("t7", 8'h02, 8'hB7, 8'h10, 0, 10'h0, 0, 10'h0, 0, 10'h0);
    check("t7_busy_end", 16'(busy_o), 16'd0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
